muldiv_unit: RTL

Iterative multiply/divide unit that sits in EX beside the ALU. It is fed the same forwarded operands a/b as the ALU and owns the architectural HI/LO registers, which mfhi/mflo read downstream. The combinational divider path is replaced by a 1-bit-per-cycle shift-add multiplier and restoring divider. A stall output freezes IF/ID/EX while an operation is in flight.

---
 rtl/muldiv_unit.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// Iterative shift-add multiplier / restoring divider owning the HI/LO registers.
// Optional MULDIV_FAST_ZERO_EN: zero-operand multiplies and divide-by-zero skip the iteration phase.
//
// state  | meaning
// IDLE   | waiting for start; mthi/mtlo writes accepted here
// CALC   | one multiply/divide iteration per clock, WIDTH iterations
// FIX    | sign correction, HI/LO write, done pulse
module muldiv_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cancel,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             stall,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_FIX  = 2'd2;

   logic [1:0]         state;
   logic               is_div, neg_lo, neg_hi, div0, done_q;
   logic [WIDTH-1:0]   a_raw, opnd, hi_q, lo_q;
   logic [2*WIDTH-1:0] acc;
   logic [CNT_W-1:0]   cnt;

   logic               a_neg, b_neg, fast_zero;
   logic [WIDTH-1:0]   abs_a, abs_b;
   logic [WIDTH:0]     sum, rem_sh;
   logic [WIDTH+1:0]   diff;
   logic [2*WIDTH-1:0] mul_nxt, div_nxt, prod_fix;
   logic [WIDTH-1:0]   fix_hi, fix_lo;

   assign a_neg = ~op[0] & a[WIDTH-1];
   assign b_neg = ~op[0] & b[WIDTH-1];
   assign abs_a = a_neg ? -a : a;
   assign abs_b = b_neg ? -b : b;

`ifdef MULDIV_FAST_ZERO_EN
   assign fast_zero = op[1] ? (b == '0) : ((a == '0) || (b == '0));
`else
   assign fast_zero = 1'b0;
`endif

   // Multiply: acc = {partial product, remaining multiplier bits}; carry shifts back in.
   assign sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + ({1'b0, opnd} & {(WIDTH+1){acc[0]}});
   assign mul_nxt = {sum, acc[WIDTH-1:1]};

   // Divide: acc = {remainder, quotient}; shifted remainder needs one extra bit.
   assign rem_sh  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
   assign diff    = {1'b0, rem_sh} - {2'b00, opnd};
   assign div_nxt = diff[WIDTH+1] ? {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                  : {diff[WIDTH-1:0],   acc[WIDTH-2:0], 1'b1};

   always_comb begin
      prod_fix = neg_lo ? -acc : acc;
      fix_hi   = prod_fix[2*WIDTH-1:WIDTH];
      fix_lo   = prod_fix[WIDTH-1:0];
      if (div0) begin
         fix_hi = a_raw;
         fix_lo = '1;
      end else if (is_div) begin
         fix_lo = neg_lo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
         fix_hi = neg_hi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= S_IDLE;
         is_div <= 1'b0;
         neg_lo <= 1'b0;
         neg_hi <= 1'b0;
         div0   <= 1'b0;
         done_q <= 1'b0;
         a_raw  <= '0;
         opnd   <= '0;
         acc    <= '0;
         cnt    <= '0;
         hi_q   <= '0;
         lo_q   <= '0;
      end else begin
         done_q <= 1'b0;
         case (state)
            S_IDLE: begin
               if (!start) begin
                  if (hi_we) hi_q <= wdata;
                  if (lo_we) lo_q <= wdata;
               end else if (!cancel) begin
                  is_div <= op[1];
                  a_raw  <= a;
                  div0   <= op[1] & (b == '0);
                  neg_lo <= a_neg ^ b_neg;
                  cnt    <= '0;
                  if (op[1]) begin
                     neg_hi <= a_neg;
                     opnd   <= abs_b;
                     acc    <= {{WIDTH{1'b0}}, abs_a};
                  end else begin
                     neg_hi <= 1'b0;
                     opnd   <= abs_a;
                     acc    <= fast_zero ? '0 : {{WIDTH{1'b0}}, abs_b};
                  end
                  state <= fast_zero ? S_FIX : S_CALC;
               end
            end
            S_CALC: begin
               if (cancel) begin
                  state <= S_IDLE;
               end else begin
                  acc <= is_div ? div_nxt : mul_nxt;
                  cnt <= cnt + 1'b1;
                  if (cnt == CNT_W'(WIDTH-1)) state <= S_FIX;
               end
            end
            S_FIX: begin
               state <= S_IDLE;
               if (!cancel) begin
                  hi_q   <= fix_hi;
                  lo_q   <= fix_lo;
                  done_q <= 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign busy  = (state != S_IDLE);
   assign stall = busy | (start & (state == S_IDLE));
   assign done  = done_q;
   assign hi    = hi_q;
   assign lo    = lo_q;

endmodule
